// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search controller.
//   sar_state_e   : controller state encoding (idle, trial in progress, done pulse)
//   SETTLE_MAX    : largest supported per-trial settle wait
//   SETTLE_W      : settle counter width, sized to hold SETTLE_MAX
//   sar_width_ok  : legal code-width range check used at elaboration
package sar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRIAL,
        ST_DONE
    } sar_state_e;

    localparam int unsigned SETTLE_MAX = 15;
    localparam int unsigned SETTLE_W   = $clog2(SETTLE_MAX + 1);

    function automatic bit sar_width_ok(input int unsigned w);
        return (w >= 2) && (w <= 16);
    endfunction

endpackage

// File: rtl/sar_settle_cnt.sv
// Loadable down-counter pacing the settle wait of each trial.
//   clk      : clock
//   rst      : synchronous active-high reset (count to zero)
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one; holds at zero
//   cnt      : current count
//   zero     : count equals zero
module sar_settle_cnt #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller. Drives a WIDTH-bit trial code y to an external
// DAC/comparator, waits SETTLE cycles per trial, and resolves one bit per trial MSB-first from
// cmp_hi. The final code is the largest code for which the comparator stayed low.
// Optional feature macro: SAR_EARLY_EXIT_EN adds cmp_eq; an exact match ends the search early.
//   clk     : clock, all logic on posedge
//   rst     : synchronous active-high reset
//   start   : begin conversion (accepted only in idle)
//   abort   : cancel conversion, back to idle, no done (wins over start)
//   cmp_eq  : comparator equality flag (only with SAR_EARLY_EXIT_EN)
//   cmp_hi  : comparator, 1 = trial code above analog input
//   y       : trial code to DAC; holds the result while idle
//   x       : bit index under trial
//   result  : final code, held until the next conversion completes
//   busy    : conversion in progress, including the done cycle
//   done    : one-cycle pulse, result valid in the same cycle
module sar_search_ctrl
    import sar_pkg::*;
#(
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned SETTLE = 0,
    parameter int unsigned IDX_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
`ifdef SAR_EARLY_EXIT_EN
    input  logic             cmp_eq,
`endif
    input  logic             cmp_hi,
    output logic [WIDTH-1:0] y,
    output logic [IDX_W-1:0] x,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    if (!sar_width_ok(WIDTH) || (SETTLE > SETTLE_MAX)) begin : g_bad_param
        $error("sar_search_ctrl: WIDTH must be 2..16 and SETTLE 0..15");
    end

    localparam logic [WIDTH-1:0]    ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0]    MSB_MASK = ONE << (WIDTH - 1);
    localparam logic [IDX_W-1:0]    X_MSB    = IDX_W'(WIDTH - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_V = SETTLE_W'(SETTLE);

    sar_state_e       state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [IDX_W-1:0] x_q, x_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic                cnt_load;
    logic                cnt_dec;
    logic                cnt_zero;
    logic [SETTLE_W-1:0] cnt_val;
    logic                eq_hit;
    logic [WIDTH-1:0]    bit_mask;
    logic [WIDTH-1:0]    y_trial;

    sar_settle_cnt #(
        .CNT_W (SETTLE_W)
    ) u_settle_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (SETTLE_V),
        .dec      (cnt_dec),
        .cnt      (cnt_val),
        .zero     (cnt_zero)
    );

`ifdef SAR_EARLY_EXIT_EN
    assign eq_hit = cmp_eq;
`else
    assign eq_hit = 1'b0;
`endif

    // One-hot mask of the bit under trial.
    assign bit_mask = ONE << x_q;

    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        x_d      = x_q;
        result_d = result_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        y_trial  = cmp_hi ? (y_q & ~bit_mask) : y_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!abort && start) begin
                    y_d      = MSB_MASK;
                    x_d      = X_MSB;
                    cnt_load = 1'b1;
                    state_d  = ST_TRIAL;
                end
            end
            ST_TRIAL: begin
                if (abort) begin
                    // Return y to the last good result so the idle invariant holds.
                    y_d     = result_q;
                    x_d     = '0;
                    state_d = ST_IDLE;
                end else if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (eq_hit) begin
                    // Exact match: current trial bit stays set, lower bits are already zero.
                    result_d = y_q;
                    state_d  = ST_DONE;
                end else if (x_q != '0) begin
                    y_d      = y_trial | (bit_mask >> 1);
                    x_d      = x_q - IDX_W'(1);
                    cnt_load = 1'b1;
                end else begin
                    y_d      = y_trial;
                    result_d = y_trial;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            y_q      <= '0;
            x_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            x_q      <= x_d;
            result_q <= result_d;
        end
    end

    assign y      = y_q;
    assign x      = x_q;
    assign result = result_q;
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);

    logic unused_cnt;
    assign unused_cnt = ^cnt_val;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: two instances (SETTLE=0 and SETTLE=2) driven by a comparator model
// cmp_hi = (y > vin), cmp_eq = (y == vin). Expected results go into per-instance queues and
// are popped by monitors on every done pulse.
module tb_sar_search_ctrl;

    logic       clk;
    logic       rst;
    logic [1:0] start;
    logic [1:0] abort;
    logic [1:0] cmp_hi;
    logic [1:0] cmp_eq;
    logic [1:0] busy_w;
    logic [1:0] done_w;
    logic [9:0] vin      [2];
    logic [9:0] y_w      [2];
    logic [3:0] x_w      [2];
    logic [9:0] result_w [2];

    int unsigned exp_q0[$];
    int unsigned exp_q1[$];
    int n_tests = 0;
    int n_fail  = 0;

    sar_search_ctrl #(.WIDTH(10), .SETTLE(0)) dut0 (
        .clk    (clk),
        .rst    (rst),
        .start  (start[0]),
        .abort  (abort[0]),
`ifdef SAR_EARLY_EXIT_EN
        .cmp_eq (cmp_eq[0]),
`endif
        .cmp_hi (cmp_hi[0]),
        .y      (y_w[0]),
        .x      (x_w[0]),
        .result (result_w[0]),
        .busy   (busy_w[0]),
        .done   (done_w[0])
    );

    sar_search_ctrl #(.WIDTH(10), .SETTLE(2)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .start  (start[1]),
        .abort  (abort[1]),
`ifdef SAR_EARLY_EXIT_EN
        .cmp_eq (cmp_eq[1]),
`endif
        .cmp_hi (cmp_hi[1]),
        .y      (y_w[1]),
        .x      (x_w[1]),
        .result (result_w[1]),
        .busy   (busy_w[1]),
        .done   (done_w[1])
    );

    assign cmp_hi[0] = (y_w[0] > vin[0]);
    assign cmp_hi[1] = (y_w[1] > vin[1]);
    assign cmp_eq[0] = (y_w[0] == vin[0]);
    assign cmp_eq[1] = (y_w[1] == vin[1]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done_w[0]) begin
            if (exp_q0.size() == 0) check("unexpected_done0", 1, 0);
            else check("result0", result_w[0], exp_q0.pop_front());
        end
        if (done_w[1]) begin
            if (exp_q1.size() == 0) check("unexpected_done1", 1, 0);
            else check("result1", result_w[1], exp_q1.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One conversion on instance s. mid_start: cycle index at which a stray start is pulsed.
    task automatic run_conv(input int s, input logic [9:0] vin_v, input logic [9:0] exp_r,
                            input int exp_lat, input int mid_start);
        int per;
        int k;
        int busy_cnt;
        int y_bad;
        bit got;
        logic [9:0] prev;
        per = (s == 0) ? 1 : 3;
        vin[s] = vin_v;
        if (s == 0) exp_q0.push_back(exp_r);
        else exp_q1.push_back(exp_r);
        start[s] = 1'b1;
        tick();
        start[s] = 1'b0;
        busy_cnt = 0;
        y_bad = 0;
        got = 1'b0;
        k = 0;
        prev = y_w[s];
        if (busy_w[s] && !done_w[s]) busy_cnt++;
        while (!got && k < 200) begin
            start[s] = (k == mid_start);
            tick();
            k++;
            if (done_w[s]) begin
                got = 1'b1;
            end else begin
                if (busy_w[s]) busy_cnt++;
                // y may only move on the resolving edge of each trial.
                if (((k % per) == 0) != (y_w[s] != prev)) y_bad++;
            end
            prev = y_w[s];
        end
        start[s] = 1'b0;
        check("latency", k, exp_lat);
        check("busy_trial_cycles", busy_cnt, exp_lat);
        check("y_settle_violations", y_bad, 0);
        check("busy_in_done", busy_w[s], 1);
        tick();
        check("busy_after", busy_w[s], 0);
        check("done_after", done_w[s], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = '0;
        abort = '0;
        vin[0] = '0;
        vin[1] = '0;
        tick();
        tick();
        for (int s = 0; s < 2; s++) begin
            check("rst_y", y_w[s], 0);
            check("rst_x", x_w[s], 0);
            check("rst_result", result_w[s], 0);
            check("rst_busy", busy_w[s], 0);
            check("rst_done", done_w[s], 0);
        end
        rst = 1'b0;
        tick();

        // Basic conversions and extremes.
        run_conv(0, 10'd630, 10'd630, 10, -1);
        check("y_holds_result", y_w[0], 630);
        run_conv(0, 10'd780, 10'd780, 10, -1);
        run_conv(0, 10'd0, 10'd0, 10, -1);
        run_conv(0, 10'd1023, 10'd1023, 10, -1);

        // SETTLE=2 with a stray start mid-run.
        run_conv(1, 10'd300, 10'd300, 30, 10);

        // Reset during trial 4.
        vin[0] = 10'd500;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_y", y_w[0], 0);
        check("midrst_x", x_w[0], 0);
        check("midrst_busy", busy_w[0], 0);
        check("midrst_result", result_w[0], 0);
        check("midrst_done", done_w[0], 0);
        tick();
        run_conv(0, 10'd777, 10'd777, 10, -1);

        // Abort during trial 6.
        run_conv(0, 10'd630, 10'd630, 10, -1);
        vin[0] = 10'd100;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("pre_abort_busy", busy_w[0], 1);
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        check("abort_busy", busy_w[0], 0);
        check("abort_result", result_w[0], 630);
        check("abort_done", done_w[0], 0);
        for (int i = 0; i < 15; i++) tick();

        // start and abort together in idle: stays idle.
        start[0] = 1'b1;
        abort[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        abort[0] = 1'b0;
        check("start_abort_idle", busy_w[0], 0);
        tick();

`ifdef SAR_EARLY_EXIT_EN
        run_conv(0, 10'd512, 10'd512, 1, -1);
        run_conv(0, 10'd513, 10'd513, 10, -1);
`endif

        tick();
        check("queues_drained", exp_q0.size() + exp_q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
